// File: rtl/msk_demodulator.sv
// msk_demodulator
//   Receive side of the MSK link. Takes the 8-bit sine-table sample stream,
//   SAMPLES_PER_BIT samples per symbol, and decides each symbol from its
//   shape: a full sine cycle is a 0, a single half-cycle lobe is a 1. It also
//   tracks the lobe polarity the modulator should have used and flags frames
//   where it did not match. BITS_PER_FRAME symbols are packed LSB first into
//   one output byte.
//
// Ports
//   G_CLK_RX   in   receive clock, one sample per enabled cycle
//   reset      in   asynchronous active-low reset
//   enable     in   data_in carries a valid sample this cycle
//   sync       in   (with enable) this sample is idx 0 of bit 0 of a frame
//   data_in    in   unsigned sample, midpoint 2**(DATA_WIDTH-1)
//   data_out   out  last decoded byte, bit k = symbol k
//   data_valid out  one-cycle strobe when data_out/phase_err update
//   phase_err  out  1 if any symbol of that frame had the wrong polarity
//   busy       out  1 while a frame is being tracked (RUN)
module msk_demodulator #(
  parameter int DATA_WIDTH      = 8,
  parameter int SAMPLES_PER_BIT = 32,
  parameter int BITS_PER_FRAME  = 8
) (
  input  logic                  G_CLK_RX,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sync,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  phase_err,
  output logic                  busy
);

  localparam int SW = $clog2(SAMPLES_PER_BIT);
  localparam int BW = (BITS_PER_FRAME > 1) ? $clog2(BITS_PER_FRAME) : 1;

  localparam logic [DATA_WIDTH-1:0] MID      = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [SW-1:0]         IDX_ONE  = SW'(1);
  localparam logic [SW-1:0]         IDX_HALF = SW'(SAMPLES_PER_BIT / 2);
  localparam logic [SW-1:0]         IDX_LAST = SW'(SAMPLES_PER_BIT - 1);
  localparam logic [SW-1:0]         THRESH   = SW'(SAMPLES_PER_BIT / 4);
  localparam logic [BW-1:0]         BIT_ONE  = BW'(1);
  localparam logic [BW-1:0]         BIT_LAST = BW'(BITS_PER_FRAME - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q, state_d;
  logic [SW-1:0]             samp_idx_q, samp_idx_d;
  logic [BW-1:0]             bit_idx_q, bit_idx_d;
  // Counts never exceed SAMPLES_PER_BIT/2 - 1, so SW bits are enough.
  logic [SW-1:0]             cnt1_q, cnt1_d;
  logic [SW-1:0]             cnt2_q, cnt2_d;
  logic [BITS_PER_FRAME-1:0] shift_q, shift_d;
  logic                      exp_phase_q, exp_phase_d;
  logic                      err_q, err_d;
  // Set on the last decision of a frame; the byte is published next clock.
  logic                      done_q, done_d;
  logic [DATA_WIDTH-1:0]     data_out_q, data_out_d;
  logic                      data_valid_q, data_valid_d;
  logic                      phase_err_q, phase_err_d;

  logic [SW-1:0] above;
  logic          m1, m2, bit_dec, obs_phase;

  always_comb begin
    state_d      = state_q;
    samp_idx_d   = samp_idx_q;
    bit_idx_d    = bit_idx_q;
    cnt1_d       = cnt1_q;
    cnt2_d       = cnt2_q;
    shift_d      = shift_q;
    exp_phase_d  = exp_phase_q;
    err_d        = err_q;
    done_d       = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    phase_err_d  = phase_err_q;

    above     = {{(SW-1){1'b0}}, (data_in > MID)};
    m1        = (cnt1_q >= THRESH);
    m2        = (cnt2_q >= THRESH);
    bit_dec   = (m1 == m2);
    obs_phase = ~m1;

    // Publish the frame assembled on the previous clock. This cycle always
    // sits at idx 0 of bit 0, where nothing below writes shift/err.
    if (done_q) begin
      data_out_d   = DATA_WIDTH'(shift_q);
      phase_err_d  = err_q;
      data_valid_d = 1'b1;
      shift_d      = '0;
      err_d        = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable && sync) begin
          state_d     = RUN;
          samp_idx_d  = IDX_ONE;
          bit_idx_d   = '0;
          cnt1_d      = '0;
          cnt2_d      = '0;
          shift_d     = '0;
          err_d       = 1'b0;
          exp_phase_d = 1'b0;
        end
      end
      RUN: begin
        if (enable) begin
          if (sync && !(samp_idx_q == '0 && bit_idx_q == '0)) begin
            // Resynchronise: drop the partial frame, this sample is idx 0.
            samp_idx_d  = IDX_ONE;
            bit_idx_d   = '0;
            cnt1_d      = '0;
            cnt2_d      = '0;
            shift_d     = '0;
            err_d       = 1'b0;
            exp_phase_d = 1'b0;
          end else begin
            samp_idx_d = samp_idx_q + IDX_ONE;  // power of 2: wraps for free
            // idx 0 and the last idx sit on zero crossings and are skipped.
            if (samp_idx_q != '0 && samp_idx_q < IDX_HALF) begin
              cnt1_d = cnt1_q + above;
            end else if (samp_idx_q >= IDX_HALF && samp_idx_q != IDX_LAST) begin
              cnt2_d = cnt2_q + above;
            end
            if (samp_idx_q == IDX_LAST) begin
              shift_d[bit_idx_q] = bit_dec;
              err_d              = err_d | (obs_phase != exp_phase_q);
              cnt1_d             = '0;
              cnt2_d             = '0;
              if (bit_idx_q == BIT_LAST) begin
                bit_idx_d   = '0;
                exp_phase_d = 1'b0;
                done_d      = 1'b1;
              end else begin
                bit_idx_d   = bit_idx_q + BIT_ONE;
                // A half-cycle symbol leaves the carrier inverted.
                exp_phase_d = exp_phase_q ^ bit_dec;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge G_CLK_RX or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      samp_idx_q   <= '0;
      bit_idx_q    <= '0;
      cnt1_q       <= '0;
      cnt2_q       <= '0;
      shift_q      <= '0;
      exp_phase_q  <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      phase_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_idx_q   <= samp_idx_d;
      bit_idx_q    <= bit_idx_d;
      cnt1_q       <= cnt1_d;
      cnt2_q       <= cnt2_d;
      shift_q      <= shift_d;
      exp_phase_q  <= exp_phase_d;
      err_q        <= err_d;
      done_q       <= done_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      phase_err_q  <= phase_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign phase_err  = phase_err_q;
  assign busy       = (state_q == RUN);

endmodule
